// File: rtl/aes_pipe_scheduler_if.sv
// Handshake between the scheduler, the input FIFO, the round pipeline and the output buffer.
interface aes_pipe_scheduler_if #(
   parameter int pTAG_WIDTH = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic                  issue_o;
   logic [pTAG_WIDTH-1:0] issue_tag_o;
   logic                  ret_valid_o;
   logic [pTAG_WIDTH-1:0] ret_tag_o;
   logic                  out_free_i;

   modport master (
      input  in_valid, out_free_i,
      output in_ready, issue_o, issue_tag_o, ret_valid_o, ret_tag_o
   );

   modport slave (
      output in_valid, out_free_i,
      input  in_ready, issue_o, issue_tag_o, ret_valid_o, ret_tag_o
   );
endinterface

// File: rtl/aes_pipe_scheduler.sv
// Issue/retire controller for a pipelined AES core: paces block issue, tracks output credits,
// tags blocks through the round pipeline and sequences key-schedule reloads.
module aes_pipe_scheduler #(
   parameter int pSTAGES         = 11,
   parameter int pISSUE_INTERVAL = 2,
   parameter int pOUT_DEPTH      = 16,
   parameter int pCOUNT_WIDTH    = 16,
   parameter int pTAG_WIDTH      = 8
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         go,
   input  logic [pCOUNT_WIDTH-1:0]      count,
   input  logic                         abort,
   input  logic                         key_load,
   output logic                         ks_load_o,
   input  logic                         ks_done_i,
   aes_pipe_scheduler_if.master         bus,
   output logic                         busy_o,
   output logic                         done_o,
   output logic [1:0]                   state_o,
   output logic [$clog2(pSTAGES+2)-1:0] inflight_o,
   input  logic                         clear_errors,
   output logic [2:0]                   errors_o
);

   localparam int INF_W  = $clog2(pSTAGES + 2);
   localparam int CRED_W = $clog2(pOUT_DEPTH + 1);
   localparam int IVL_W  = $clog2(pISSUE_INTERVAL + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      KEY   = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [pCOUNT_WIDTH-1:0] r_remaining;
   logic [CRED_W-1:0]       r_credits;
   logic [pTAG_WIDTH-1:0]   r_tag;
   logic [IVL_W-1:0]        r_ivl_cnt;
   logic [INF_W-1:0]        r_inflight;
   logic                    r_key_pending;
   logic                    r_ks_load;
   logic                    r_done_zero;
   logic [2:0]              r_err;
   logic                    r_issue;
   logic [pTAG_WIDTH-1:0]   r_issue_tag;
   logic                    r_vld_sr [pSTAGES];
   logic [pTAG_WIDTH-1:0]   r_tag_sr [pSTAGES];

   logic w_pop;
   logic w_ret;
   logic w_start;
   logic w_free_ok;
   logic w_ovf;
   logic w_go_ign;
   logic w_key_ign;
   logic w_done_zero_nxt;
   logic w_drain_exit;

   always_comb begin
      w_state_nxt     = r_state;
      w_go_ign        = 1'b0;
      w_key_ign       = 1'b0;
      w_done_zero_nxt = 1'b0;
      w_start         = 1'b0;
      w_pop           = (r_state == RUN) && (r_remaining != '0) && bus.in_valid &&
                        (r_credits != '0) && (r_ivl_cnt == '0) && !abort;
      w_ret           = r_vld_sr[pSTAGES-1];
      w_drain_exit    = (r_state == DRAIN) && (r_inflight == '0);
      // A credit returned while the buffer already looks empty is an overflow, unless a pop consumes one
      w_free_ok       = bus.out_free_i && ((r_credits != CRED_W'(pOUT_DEPTH)) || w_pop);
      w_ovf           = bus.out_free_i && !w_free_ok;
      case (r_state)
         IDLE: begin
            if (key_load) begin
               w_state_nxt = KEY;
               w_go_ign    = go;
            end else if (go) begin
               if (count != '0) begin
                  w_state_nxt = RUN;
                  w_start     = 1'b1;
               end else begin
                  w_done_zero_nxt = 1'b1;
               end
            end
         end
         KEY: begin
            w_go_ign  = go;
            w_key_ign = key_load;
            if (ks_done_i) w_state_nxt = IDLE;
         end
         RUN: begin
            w_go_ign = go;
            if (abort || (r_remaining == '0)) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            w_go_ign = go;
            if (r_inflight == '0) w_state_nxt = (r_key_pending || key_load) ? KEY : IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_remaining   <= '0;
         r_credits     <= CRED_W'(pOUT_DEPTH);
         r_tag         <= '0;
         r_ivl_cnt     <= '0;
         r_inflight    <= '0;
         r_key_pending <= 1'b0;
         r_ks_load     <= 1'b0;
         r_done_zero   <= 1'b0;
         r_err         <= '0;
         r_issue       <= 1'b0;
         r_issue_tag   <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_ks_load   <= (r_state != KEY) && (w_state_nxt == KEY);
         r_done_zero <= w_done_zero_nxt;
         r_issue     <= w_pop;
         r_issue_tag <= r_tag;
         r_err       <= (clear_errors ? 3'b000 : r_err) | {w_key_ign, w_ovf, w_go_ign};

         if (w_start)    r_remaining <= count;
         else if (w_pop) r_remaining <= r_remaining - 1'b1;

         if (w_pop) r_tag <= r_tag + 1'b1;

         if (w_pop)                  r_ivl_cnt <= IVL_W'(pISSUE_INTERVAL - 1);
         else if (r_ivl_cnt != '0)   r_ivl_cnt <= r_ivl_cnt - 1'b1;

         case ({w_pop, w_free_ok})
            2'b10:   r_credits <= r_credits - 1'b1;
            2'b01:   r_credits <= r_credits + 1'b1;
            default: r_credits <= r_credits;
         endcase

         case ({w_pop, w_ret})
            2'b10:   r_inflight <= r_inflight + 1'b1;
            2'b01:   r_inflight <= r_inflight - 1'b1;
            default: r_inflight <= r_inflight;
         endcase

         if ((r_state != KEY) && (w_state_nxt == KEY))
            r_key_pending <= 1'b0;
         else if (key_load && ((r_state == RUN) || (r_state == DRAIN)))
            r_key_pending <= 1'b1;
      end
   end

   // Retire timing: issue strobe and tag travel pSTAGES cycles alongside the round pipeline
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < pSTAGES; i++) begin
            r_vld_sr[i] <= 1'b0;
            r_tag_sr[i] <= '0;
         end
      end else begin
         r_vld_sr[0] <= r_issue;
         r_tag_sr[0] <= r_issue_tag;
         for (int i = 1; i < pSTAGES; i++) begin
            r_vld_sr[i] <= r_vld_sr[i-1];
            r_tag_sr[i] <= r_tag_sr[i-1];
         end
      end
   end

   assign bus.in_ready    = w_pop;
   assign bus.issue_o     = r_issue;
   assign bus.issue_tag_o = r_issue_tag;
   assign bus.ret_valid_o = r_vld_sr[pSTAGES-1];
   assign bus.ret_tag_o   = r_tag_sr[pSTAGES-1];
   assign ks_load_o       = r_ks_load;
   assign busy_o          = (r_state != IDLE);
   assign done_o          = r_done_zero | w_drain_exit;
   assign state_o         = r_state;
   assign inflight_o      = r_inflight;
   assign errors_o        = r_err;

endmodule

// File: tb/tb_aes_pipe_scheduler.sv
// Scoreboard bench for aes_pipe_scheduler: a half-pipe instance for bursts, gaps, abort, key reload
// and error handling, plus a full-pipe shallow-buffer instance for credit stalls.
module tb_aes_pipe_scheduler;

   localparam int STG    = 11;
   localparam int IVL    = 2;
   localparam int DEP    = 16;
   localparam int CW     = 16;
   localparam int TW     = 8;
   localparam int STG_FP = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          go = 1'b0;
   logic [CW-1:0] count = '0;
   logic          abort = 1'b0;
   logic          key_load = 1'b0;
   logic          ks_done = 1'b0;
   logic          clear_err = 1'b0;
   logic          ks_load;
   logic          busy;
   logic          done;
   logic [1:0]    state;
   logic [$clog2(STG+2)-1:0] inflight;
   logic [2:0]    errors;

   aes_pipe_scheduler_if #(.pTAG_WIDTH(TW)) bus ();

   aes_pipe_scheduler #(
      .pSTAGES(STG), .pISSUE_INTERVAL(IVL), .pOUT_DEPTH(DEP), .pCOUNT_WIDTH(CW), .pTAG_WIDTH(TW)
   ) u_dut (
      .clk(clk), .reset_n(reset_n), .go(go), .count(count), .abort(abort), .key_load(key_load),
      .ks_load_o(ks_load), .ks_done_i(ks_done), .bus(bus), .busy_o(busy), .done_o(done),
      .state_o(state), .inflight_o(inflight), .clear_errors(clear_err), .errors_o(errors)
   );

   logic          go_fp = 1'b0;
   logic [CW-1:0] count_fp = '0;
   logic          ks_load_fp;
   logic          busy_fp;
   logic          done_fp;
   logic [1:0]    state_fp;
   logic [$clog2(STG_FP+2)-1:0] inflight_fp;
   logic [2:0]    errors_fp;

   aes_pipe_scheduler_if #(.pTAG_WIDTH(TW)) bus_fp ();

   aes_pipe_scheduler #(
      .pSTAGES(STG_FP), .pISSUE_INTERVAL(1), .pOUT_DEPTH(2), .pCOUNT_WIDTH(CW), .pTAG_WIDTH(TW)
   ) u_dut_fp (
      .clk(clk), .reset_n(reset_n), .go(go_fp), .count(count_fp), .abort(1'b0), .key_load(1'b0),
      .ks_load_o(ks_load_fp), .ks_done_i(1'b0), .bus(bus_fp), .busy_o(busy_fp), .done_o(done_fp),
      .state_o(state_fp), .inflight_o(inflight_fp), .clear_errors(1'b0), .errors_o(errors_fp)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [TW-1:0] tag;
      int            c;
   } exp_t;

   exp_t          sb [$];
   exp_t          e;
   int            pops [$];
   int            pops_fp [$];
   logic [TW-1:0] m_tag = '0;
   logic          prev_pop = 1'b0;
   logic [TW-1:0] prev_tag = '0;
   logic          ret_prev = 1'b0;
   int            n_ret = 0;
   int            done_c = -1;
   int            done_fp_c = -1;

   // Reference model: every observed pop predicts its issue strobe one cycle later and its retire pSTAGES after that
   always @(negedge clk) begin
      if (!reset_n) begin
         sb.delete();
         m_tag    = '0;
         prev_pop = 1'b0;
         ret_prev = 1'b0;
      end else begin
         if (prev_pop || bus.issue_o)
            chk("issue", int'({bus.issue_o, bus.issue_tag_o}), int'({prev_pop, prev_tag}));
         prev_pop = bus.in_ready;
         prev_tag = m_tag;
         if (bus.in_ready) begin
            sb.push_back('{m_tag, cyc});
            pops.push_back(cyc);
            m_tag = m_tag + 1'b1;
         end
         ret_prev = bus.ret_valid_o;
         if (bus.ret_valid_o) begin
            n_ret++;
            if (sb.size() == 0) begin
               chk("ret_spurious", int'(bus.ret_valid_o), 0);
            end else begin
               e = sb.pop_front();
               chk("ret_tag", int'(bus.ret_tag_o), int'(e.tag));
               chk("ret_cyc", cyc, e.c + 1 + STG);
            end
         end
         if (done) done_c = cyc;
         if (bus_fp.in_ready) pops_fp.push_back(cyc);
         if (done_fp) done_fp_c = cyc;
      end
   end

   logic man_free = 1'b0;

   // Output buffer model: each retired block frees its slot one cycle later
   initial begin
      bus.out_free_i = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         bus.out_free_i = ret_prev | man_free;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic start(input int n, output int c0);
      c0    = cyc;
      go    = 1'b1;
      count = CW'(n);
      step(1);
      go    = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (done_c < 0 && k < budget) begin
         step(1);
         k++;
      end
      chk("done_seen", int'(done_c >= 0), 1);
   endtask

   task automatic wait_pops(input int n, input int budget);
      int k;
      k = 0;
      while (pops.size() < n && k < budget) begin
         step(1);
         k++;
      end
      chk("pops_reached", int'(pops.size() >= n), 1);
   endtask

   task automatic new_test();
      pops.delete();
      done_c = -1;
   endtask

   function automatic int out_vec();
      return int'({ks_load, busy, done, state, inflight, errors, bus.in_ready, bus.issue_o,
                   bus.issue_tag_o, bus.ret_valid_o, bus.ret_tag_o});
   endfunction

   initial begin
      int c0;
      int g0;
      int r0;
      bus.in_valid    = 1'b0;
      bus_fp.in_valid = 1'b0;
      bus_fp.out_free_i = 1'b0;
      step(3);
      chk("reset_outputs", out_vec(), 0);
      reset_n = 1'b1;
      bus.in_valid = 1'b1;
      step(2);

      // half pipe burst of 4
      new_test();
      start(4, c0);
      wait_done(60);
      chk("t1_npop", pops.size(), 4);
      for (int i = 0; i < 4 && i < pops.size(); i++) chk("t1_pop_cyc", pops[i] - c0, 1 + 2 * i);
      chk("t1_done_cyc", done_c - c0, 20);
      chk("t1_state", int'(state), 0);
      step(2);

      // input FIFO empty for 5 cycles mid-burst
      new_test();
      start(6, c0);
      wait_pops(2, 20);
      g0 = cyc;
      bus.in_valid = 1'b0;
      step(5);
      bus.in_valid = 1'b1;
      wait_done(80);
      chk("t2_npop", pops.size(), 6);
      if (pops.size() == 6) begin
         chk("t2_resume", pops[2] - g0, 5);
         chk("t2_last_pop", pops[5] - g0, 11);
         chk("t2_done_cyc", done_c - pops[5], STG + 2);
      end
      step(2);

      // abort one cycle after the second pop
      new_test();
      start(6, c0);
      wait_pops(2, 20);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      wait_done(40);
      chk("t3_npop", pops.size(), 2);
      chk("t3_done_cyc", done_c - c0, 16);
      chk("t3_state", int'(state), 0);
      step(2);

      // key reload requested mid-burst
      new_test();
      start(3, c0);
      wait_pops(1, 20);
      key_load = 1'b1;
      step(1);
      key_load = 1'b0;
      wait_done(40);
      chk("t4_npop", pops.size(), 3);
      chk("t4_done_cyc", done_c - c0, 18);
      chk("t4_key_state", int'(state), 1);
      chk("t4_ks_load_pulse", int'(ks_load), 1);
      step(1);
      chk("t4_ks_load_once", int'(ks_load), 0);
      chk("t4_still_key", int'(state), 1);
      key_load = 1'b1;
      step(1);
      key_load = 1'b0;
      chk("t4_key_ign_err", int'(errors), 3'b100);
      ks_done = 1'b1;
      step(1);
      ks_done = 1'b0;
      chk("t4_back_idle", int'(state), 0);
      clear_err = 1'b1;
      step(1);
      clear_err = 1'b0;
      chk("t4_err_clear", int'(errors), 0);

      // zero-length burst
      new_test();
      start(0, c0);
      chk("t5_done_zero", int'(done), 1);
      chk("t5_state", int'(state), 0);
      step(1);
      chk("t5_done_pulse", int'(done), 0);

      // error flags, clear priority and reset mid-burst
      man_free = 1'b1;
      step(1);
      man_free = 1'b0;
      chk("t6_ovf", int'(errors), 3'b010);
      new_test();
      start(4, c0);
      wait_pops(1, 20);
      go = 1'b1;
      count = CW'(5);
      step(1);
      go = 1'b0;
      chk("t6_err011", int'(errors), 3'b011);
      step(2);
      chk("t6_sticky", int'(errors), 3'b011);
      clear_err = 1'b1;
      go = 1'b1;
      step(1);
      clear_err = 1'b0;
      go = 1'b0;
      chk("t6_set_wins", int'(errors), 3'b001);
      clear_err = 1'b1;
      step(1);
      clear_err = 1'b0;
      chk("t6_cleared", int'(errors), 0);
      chk("t6_busy", int'(busy), 1);
      r0 = n_ret;
      reset_n = 1'b0;
      #1;
      chk("t6_reset_outputs", out_vec(), 0);
      step(2);
      reset_n = 1'b1;
      step(25);
      chk("t6_no_ret", n_ret - r0, 0);
      chk("t6_idle", int'(state), 0);

      // full pipe, two output slots, no credits returned
      bus_fp.in_valid = 1'b1;
      pops_fp.delete();
      done_fp_c = -1;
      c0 = cyc;
      go_fp = 1'b1;
      count_fp = CW'(3);
      step(1);
      go_fp = 1'b0;
      step(3);
      chk("fp_inflight", int'(inflight_fp), 2);
      step(2);
      chk("fp_stall_npop", pops_fp.size(), 2);
      if (pops_fp.size() == 2) begin
         chk("fp_pop0", pops_fp[0] - c0, 1);
         chk("fp_pop1", pops_fp[1] - c0, 2);
      end
      bus_fp.out_free_i = 1'b1;
      step(1);
      bus_fp.out_free_i = 1'b0;
      step(1);
      chk("fp_npop", pops_fp.size(), 3);
      if (pops_fp.size() == 3) chk("fp_pop2", pops_fp[2] - c0, 7);
      for (int k = 0; k < 30 && done_fp_c < 0; k++) step(1);
      chk("fp_done_cyc", done_fp_c - c0, 13);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
